// File: rtl/busio_pkg.sv
// Shared encodings for the core's bus responder: access sizes and FSM states.
package busio_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MEM   = 2'd2
  } state_t;

endpackage

// File: rtl/busio_align.sv
// Byte-lane steering: store replication and strobes, load lane pick and extension.
// Purely combinational; the store path and load path are independent.
module busio_align
  import busio_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_strobe,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_signed,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata  = st_data;
    st_strobe = 4'b1111;
    case (st_size)
      SIZE_BYTE: begin
        st_wdata  = {4{st_data[7:0]}};
        st_strobe = 4'b0001 << st_lo;
      end
      SIZE_HALF: begin
        st_wdata  = {2{st_data[15:0]}};
        st_strobe = 4'b0011 << {st_lo[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_lo)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_size)
      SIZE_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default:   ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/busio.sv
// Arbitrates fetch and data ports onto one valid/ready word bus; one-entry fetch buffer.
// Request latched in IDLE, ext_valid next cycle, ready one cycle after the ext handshake.
module busio
  import busio_pkg::*;
#(
  parameter bit MEM_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic        mem_load,
  input  logic        mem_store,
  output logic [31:0] mem_load_data,
  output logic        mem_ready,
  output logic        ext_valid,
  input  logic        ext_ready,
  output logic [31:0] ext_address,
  output logic        ext_write,
  output logic [31:0] ext_write_data,
  output logic [3:0]  ext_write_strobe,
  input  logic [31:0] ext_read_data
);

  state_t      state_q, state_d;
  logic        ext_valid_q, ext_valid_d;
  logic [31:0] ext_address_q, ext_address_d;
  logic        ext_write_q, ext_write_d;
  logic [31:0] ext_wdata_q, ext_wdata_d;
  logic [3:0]  ext_strobe_q, ext_strobe_d;
  logic        fbuf_valid_q, fbuf_valid_d;
  logic [29:0] fbuf_addr_q, fbuf_addr_d;
  logic [31:0] fbuf_data_q, fbuf_data_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] load_data_q, load_data_d;
  logic [1:0]  cap_lo_q, cap_lo_d;
  logic [1:0]  cap_size_q, cap_size_d;
  logic        cap_signed_q, cap_signed_d;

  logic        mem_any, mem_req, fetch_miss;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_strobe;
  logic        unused_fetch_lo;

  assign unused_fetch_lo = ^fetch_address[1:0];

  busio_align u_align (
    .st_size   (mem_size),
    .st_lo     (mem_address[1:0]),
    .st_data   (mem_store_data),
    .st_wdata  (st_wdata),
    .st_strobe (st_strobe),
    .ld_size   (cap_size_q),
    .ld_lo     (cap_lo_q),
    .ld_signed (cap_signed_q),
    .ld_word   (ext_read_data),
    .ld_data   (ld_data)
  );

  assign mem_any     = mem_load | mem_store;
  assign mem_req     = mem_any && !mem_done_q;
  assign fetch_ready = fbuf_valid_q && (fbuf_addr_q == fetch_address[31:2]);
  assign fetch_miss  = !fetch_ready;

  assign fetch_data       = fbuf_data_q;
  assign mem_ready        = mem_done_q || !mem_any;
  assign mem_load_data    = load_data_q;
  assign ext_valid        = ext_valid_q;
  assign ext_address      = ext_address_q;
  assign ext_write        = ext_write_q;
  assign ext_write_data   = ext_wdata_q;
  assign ext_write_strobe = ext_strobe_q;

  always_comb begin
    state_d       = state_q;
    ext_valid_d   = ext_valid_q;
    ext_address_d = ext_address_q;
    ext_write_d   = ext_write_q;
    ext_wdata_d   = ext_wdata_q;
    ext_strobe_d  = ext_strobe_q;
    fbuf_valid_d  = fbuf_valid_q;
    fbuf_addr_d   = fbuf_addr_q;
    fbuf_data_d   = fbuf_data_q;
    mem_done_d    = 1'b0;
    load_data_d   = load_data_q;
    cap_lo_d      = cap_lo_q;
    cap_size_d    = cap_size_q;
    cap_signed_d  = cap_signed_q;
    case (state_q)
      IDLE: begin
        if (mem_req && (MEM_FIRST || !fetch_miss)) begin
          state_d       = MEM;
          ext_valid_d   = 1'b1;
          ext_address_d = {mem_address[31:2], 2'b00};
          ext_write_d   = mem_store;
          ext_wdata_d   = mem_store ? st_wdata : 32'h0;
          ext_strobe_d  = mem_store ? st_strobe : 4'b0000;
          cap_lo_d      = mem_address[1:0];
          cap_size_d    = mem_size;
          cap_signed_d  = mem_signed;
        end else if (fetch_miss) begin
          state_d       = FETCH;
          ext_valid_d   = 1'b1;
          ext_address_d = {fetch_address[31:2], 2'b00};
          ext_write_d   = 1'b0;
          ext_wdata_d   = 32'h0;
          ext_strobe_d  = 4'b0000;
        end
      end
      FETCH: begin
        if (ext_ready) begin
          state_d      = IDLE;
          ext_valid_d  = 1'b0;
          fbuf_valid_d = 1'b1;
          fbuf_addr_d  = ext_address_q[31:2];
          fbuf_data_d  = ext_read_data;
        end
      end
      MEM: begin
        if (ext_ready) begin
          state_d     = IDLE;
          ext_valid_d = 1'b0;
          // A result is only presented if the pipeline is still asking for it.
          mem_done_d  = mem_any;
          if (ext_write_q) begin
            if (ext_address_q[31:2] == fbuf_addr_q) fbuf_valid_d = 1'b0;
          end else begin
            load_data_d = ld_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ext_valid_q   <= 1'b0;
      ext_address_q <= 32'h0;
      ext_write_q   <= 1'b0;
      ext_wdata_q   <= 32'h0;
      ext_strobe_q  <= 4'b0000;
      fbuf_valid_q  <= 1'b0;
      fbuf_addr_q   <= 30'h0;
      fbuf_data_q   <= 32'h0;
      mem_done_q    <= 1'b0;
      load_data_q   <= 32'h0;
      cap_lo_q      <= 2'd0;
      cap_size_q    <= SIZE_BYTE;
      cap_signed_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ext_valid_q   <= ext_valid_d;
      ext_address_q <= ext_address_d;
      ext_write_q   <= ext_write_d;
      ext_wdata_q   <= ext_wdata_d;
      ext_strobe_q  <= ext_strobe_d;
      fbuf_valid_q  <= fbuf_valid_d;
      fbuf_addr_q   <= fbuf_addr_d;
      fbuf_data_q   <= fbuf_data_d;
      mem_done_q    <= mem_done_d;
      load_data_q   <= load_data_d;
      cap_lo_q      <= cap_lo_d;
      cap_size_q    <= cap_size_d;
      cap_signed_q  <= cap_signed_d;
    end
  end

endmodule

// File: tb/tb_busio.sv
// Directed bench for busio: inputs driven and outputs sampled on the falling edge.
module tb_busio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_address = 32'h100;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic [31:0] mem_address = 32'h0;
  logic [31:0] mem_store_data = 32'h0;
  logic [1:0]  mem_size = 2'd0;
  logic        mem_signed = 1'b0;
  logic        mem_load = 1'b0;
  logic        mem_store = 1'b0;
  logic [31:0] mem_load_data;
  logic        mem_ready;
  logic        ext_valid;
  logic        ext_ready = 1'b0;
  logic [31:0] ext_address;
  logic        ext_write;
  logic [31:0] ext_write_data;
  logic [3:0]  ext_write_strobe;
  logic [31:0] ext_read_data = 32'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  busio #(.MEM_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .fetch_address(fetch_address), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .mem_address(mem_address), .mem_store_data(mem_store_data), .mem_size(mem_size),
    .mem_signed(mem_signed), .mem_load(mem_load), .mem_store(mem_store),
    .mem_load_data(mem_load_data), .mem_ready(mem_ready),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_address(ext_address),
    .ext_write(ext_write), .ext_write_data(ext_write_data),
    .ext_write_strobe(ext_write_strobe), .ext_read_data(ext_read_data)
  );

  task automatic wait_vld(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ext_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_mrdy(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (ext_valid !== 1'b0) begin failures++; $display("FAIL rst_ext_valid got=%b exp=0", ext_valid); end
    checks++; if (fetch_ready !== 1'b0) begin failures++; $display("FAIL rst_fetch_ready got=%b exp=0", fetch_ready); end
    checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL rst_mem_ready got=%b exp=1", mem_ready); end
    checks++; if (ext_address !== 32'h0) begin failures++; $display("FAIL rst_ext_address got=%h exp=0", ext_address); end
    checks++; if (ext_write_strobe !== 4'b0) begin failures++; $display("FAIL rst_strobe got=%b exp=0000", ext_write_strobe); end
    checks++; if (ext_write_data !== 32'h0 || mem_load_data !== 32'h0) begin failures++; $display("FAIL rst_data got=%h/%h exp=0/0", ext_write_data, mem_load_data); end
  endtask

  task automatic test_fetch();
    int extra;
    ext_ready = 1'b1; ext_read_data = 32'h00500093; reset = 1'b0;
    @(negedge clk);
    checks++; if (ext_valid !== 1'b1) begin failures++; $display("FAIL fetch_issue got=%b exp=1", ext_valid); end
    checks++; if (ext_address !== 32'h100) begin failures++; $display("FAIL fetch_addr got=%h exp=00000100", ext_address); end
    checks++; if (ext_write !== 1'b0 || fetch_ready !== 1'b0) begin failures++; $display("FAIL fetch_inflight got=%b/%b exp=0/0", ext_write, fetch_ready); end
    @(negedge clk);
    checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL fetch_ready got=%b exp=1", fetch_ready); end
    checks++; if (fetch_data !== 32'h00500093) begin failures++; $display("FAIL fetch_data got=%h exp=00500093", fetch_data); end
    checks++; if (ext_valid !== 1'b0) begin failures++; $display("FAIL fetch_vld_drop got=%b exp=0", ext_valid); end
    extra = 0;
    repeat (5) begin @(negedge clk); if (ext_valid === 1'b1 || fetch_ready !== 1'b1) extra++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL fetch_hold got=%0d exp=0", extra); end
  endtask

  task automatic test_load();
    bit ok;
    @(negedge clk);
    ext_read_data = 32'h80FF7F01;
    mem_address = 32'h203; mem_size = 2'd0; mem_signed = 1'b1; mem_load = 1'b1;
    #1;
    checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL ld_pending got=%b exp=0", mem_ready); end
    @(negedge clk);
    checks++; if (ext_valid !== 1'b1 || ext_address !== 32'h200) begin failures++; $display("FAIL ld_issue got=%b/%h exp=1/00000200", ext_valid, ext_address); end
    checks++; if (ext_write !== 1'b0 || ext_write_strobe !== 4'b0000) begin failures++; $display("FAIL ld_rd got=%b/%b exp=0/0000", ext_write, ext_write_strobe); end
    @(negedge clk);
    checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL ld_sb_ready got=%b exp=1", mem_ready); end
    checks++; if (mem_load_data !== 32'hFFFFFF80) begin failures++; $display("FAIL ld_sb_data got=%h exp=ffffff80", mem_load_data); end
    mem_address = 32'h202; mem_size = 2'd1; mem_signed = 1'b0;
    @(negedge clk);
    checks++; if (mem_ready !== 1'b0 || ext_valid !== 1'b0) begin failures++; $display("FAIL ld_pulse got=%b/%b exp=0/0", mem_ready, ext_valid); end
    wait_mrdy(6, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ld_uh_timeout got=0 exp=1"); end
    checks++; if (mem_load_data !== 32'h000080FF) begin failures++; $display("FAIL ld_uh_data got=%h exp=000080ff", mem_load_data); end
    mem_load = 1'b0;
  endtask

  task automatic test_store();
    bit ok;
    @(negedge clk);
    mem_address = 32'h301; mem_size = 2'd0; mem_store_data = 32'h000000AB; mem_store = 1'b1;
    wait_vld(4, ok);
    checks++; if (!ok) begin failures++; $display("FAIL sb_timeout got=0 exp=1"); end
    checks++; if (ext_write !== 1'b1 || ext_address !== 32'h300) begin failures++; $display("FAIL sb_req got=%b/%h exp=1/00000300", ext_write, ext_address); end
    checks++; if (ext_write_data !== 32'hABABABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=abababab", ext_write_data); end
    checks++; if (ext_write_strobe !== 4'b0010) begin failures++; $display("FAIL sb_strobe got=%b exp=0010", ext_write_strobe); end
    wait_mrdy(4, ok);
    checks++; if (!ok) begin failures++; $display("FAIL sb_done got=0 exp=1"); end
    mem_address = 32'h302; mem_size = 2'd1; mem_store_data = 32'h00001234;
    wait_vld(6, ok);
    checks++; if (!ok) begin failures++; $display("FAIL sh_timeout got=0 exp=1"); end
    checks++; if (ext_write_strobe !== 4'b1100) begin failures++; $display("FAIL sh_strobe got=%b exp=1100", ext_write_strobe); end
    checks++; if (ext_write_data !== 32'h12341234) begin failures++; $display("FAIL sh_wdata got=%h exp=12341234", ext_write_data); end
    wait_mrdy(4, ok);
    checks++; if (!ok) begin failures++; $display("FAIL sh_done got=0 exp=1"); end
    mem_store = 1'b0;
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    ext_ready = 1'b0; ext_read_data = 32'hCAFEF00D;
    fetch_address = 32'h500;
    mem_address = 32'h204; mem_size = 2'd2; mem_signed = 1'b0; mem_load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ext_valid !== 1'b1 || ext_address !== 32'h204 || ext_write !== 1'b0) begin
        failures++; $display("FAIL arb_hold%0d got=%b/%h/%b exp=1/00000204/0", i, ext_valid, ext_address, ext_write);
      end
    end
    ext_ready = 1'b1;
    @(negedge clk);
    checks++; if (mem_ready !== 1'b1 || mem_load_data !== 32'hCAFEF00D) begin failures++; $display("FAIL arb_load got=%b/%h exp=1/cafef00d", mem_ready, mem_load_data); end
    checks++; if (ext_valid !== 1'b0) begin failures++; $display("FAIL arb_gap got=%b exp=0", ext_valid); end
    mem_load = 1'b0; ext_read_data = 32'h11111111;
    @(negedge clk);
    checks++; if (ext_valid !== 1'b1 || ext_address !== 32'h500) begin failures++; $display("FAIL arb_fetch got=%b/%h exp=1/00000500", ext_valid, ext_address); end
    @(negedge clk);
    checks++; if (fetch_ready !== 1'b1 || fetch_data !== 32'h11111111) begin failures++; $display("FAIL arb_fdata got=%b/%h exp=1/11111111", fetch_ready, fetch_data); end
  endtask

  task automatic test_redirect();
    @(negedge clk);
    ext_ready = 1'b0; fetch_address = 32'h100;
    @(negedge clk);
    checks++; if (ext_valid !== 1'b1 || ext_address !== 32'h100) begin failures++; $display("FAIL rd_issue got=%b/%h exp=1/00000100", ext_valid, ext_address); end
    fetch_address = 32'h400; ext_ready = 1'b1; ext_read_data = 32'hDEAD0100;
    @(negedge clk);
    checks++; if (fetch_ready !== 1'b0) begin failures++; $display("FAIL rd_stale got=%b exp=0", fetch_ready); end
    ext_read_data = 32'h00400400;
    @(negedge clk);
    checks++; if (ext_valid !== 1'b1 || ext_address !== 32'h400) begin failures++; $display("FAIL rd_refetch got=%b/%h exp=1/00000400", ext_valid, ext_address); end
    @(negedge clk);
    checks++; if (fetch_ready !== 1'b1 || fetch_data !== 32'h00400400) begin failures++; $display("FAIL rd_fdata got=%b/%h exp=1/00400400", fetch_ready, fetch_data); end
    mem_address = 32'h400; mem_size = 2'd2; mem_store_data = 32'h55; mem_store = 1'b1;
    @(negedge clk);
    checks++; if (ext_write !== 1'b1 || ext_write_strobe !== 4'b1111 || fetch_ready !== 1'b1) begin failures++; $display("FAIL coh_store got=%b/%b/%b exp=1/1111/1", ext_write, ext_write_strobe, fetch_ready); end
    @(negedge clk);
    checks++; if (mem_ready !== 1'b1 || fetch_ready !== 1'b0) begin failures++; $display("FAIL coh_inval got=%b/%b exp=1/0", mem_ready, fetch_ready); end
    mem_store = 1'b0; ext_read_data = 32'h00400401;
    @(negedge clk);
    checks++; if (ext_valid !== 1'b1 || ext_address !== 32'h400 || ext_write !== 1'b0) begin failures++; $display("FAIL coh_refetch got=%b/%h/%b exp=1/00000400/0", ext_valid, ext_address, ext_write); end
    @(negedge clk);
    checks++; if (fetch_ready !== 1'b1 || fetch_data !== 32'h00400401) begin failures++; $display("FAIL coh_fdata got=%b/%h exp=1/00400401", fetch_ready, fetch_data); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(negedge clk);
    ext_ready = 1'b0; fetch_address = 32'h600;
    @(negedge clk);
    checks++; if (ext_valid !== 1'b1) begin failures++; $display("FAIL rm_issue got=%b exp=1", ext_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (ext_valid !== 1'b0 || fetch_ready !== 1'b0) begin failures++; $display("FAIL rm_async got=%b/%b exp=0/0", ext_valid, fetch_ready); end
    @(negedge clk);
    reset = 1'b0; ext_ready = 1'b1; ext_read_data = 32'h66666666;
    wait_vld(4, ok);
    checks++; if (!ok || ext_address !== 32'h600) begin failures++; $display("FAIL rm_reissue got=%b/%h exp=1/00000600", ok, ext_address); end
    @(negedge clk);
    checks++; if (fetch_ready !== 1'b1 || fetch_data !== 32'h66666666) begin failures++; $display("FAIL rm_fdata got=%b/%h exp=1/66666666", fetch_ready, fetch_data); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_arbitration();
    test_redirect();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/busio.md
Name: busio

Overview:
- Bus responder for the five-stage core's two initiator ports: instruction fetch (address-only, read) and data memory (load/store with size/sign).
- Arbitrates both onto a single external word-wide valid/ready bus.
- Performs byte-lane steering and strobes for stores, and lane extraction with sign/zero extension for loads.
- Returns fetch_ready/mem_ready, which the hazard unit uses to stall the pipeline.

Parameters:
- MEM_FIRST, 1, when both ports are pending in IDLE: 1 = data port wins, 0 = fetch wins.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_address  in  32  instruction address; byte address, bits [1:0] ignored.
- fetch_data  out  32  instruction word for fetch_address; valid while fetch_ready.
- fetch_ready  out  1  fetch_data matches the current fetch_address.
- mem_address  in  32  data byte address.
- mem_store_data  in  32  store data, right-aligned.
- mem_size  in  2  0 = byte, 1 = half, 2/3 = word.
- mem_signed  in  1  load sign-extend (1) or zero-extend (0).
- mem_load  in  1  load request; held until mem_ready.
- mem_store  in  1  store request; held until mem_ready.
- mem_load_data  out  32  extended load result; valid while mem_ready.
- mem_ready  out  1  data request complete; high when no request is pending.
- ext_valid  out  1  external request valid.
- ext_ready  in  1  external accept; completes the transfer in the same cycle.
- ext_address  out  32  word address, {addr[31:2], 2'b00}.
- ext_write  out  1  1 = write, 0 = read.
- ext_write_data  out  32  lane-replicated store data.
- ext_write_strobe  out  4  byte enables; 0000 on reads.
- ext_read_data  in  32  read word; sampled when ext_valid && ext_ready && !ext_write.

Behaviour:
- Reset (asynchronous) values:
  - state = IDLE; ext_valid = 0; ext_address, ext_write_data, ext_write_strobe = 0; ext_write = 0.
  - fetch buffer invalid; mem_done = 0.
  - Outputs follow: fetch_ready = 0; mem_ready = !(mem_load|mem_store); data outputs = 0.
  - Reset mid-transaction drops ext_valid immediately; the external side tolerates an abandoned request.
- States and transitions:
  - IDLE → MEM: mem_req = (mem_load|mem_store) && !mem_done. The ext_* request is latched this cycle; ext_valid rises next cycle.
  - IDLE → FETCH: fetch_miss = !(fbuf_valid && fbuf_addr == fetch_address[31:2]).
  - Both mem_req and fetch_miss: MEM_FIRST decides.
  - MEM/FETCH → IDLE on ext_valid && ext_ready. ext_valid and all ext_* outputs are held stable until then.
- Fetch completion:
  - fbuf_data ← ext_read_data; fbuf_addr ← captured address; fbuf_valid ← 1.
  - fetch_ready = fbuf_valid && fbuf_addr == fetch_address[31:2] (combinational); fetch_data = fbuf_data.
  - If fetch_address changes mid-flight (branch/trap), the transfer still completes. The buffer holds the stale address, so no ready is given and a new fetch issues from IDLE.
- Mem completion:
  - mem_done ← 1 only if mem_load|mem_store is still high; otherwise the result is discarded.
  - mem_ready = mem_done || !(mem_load|mem_store).
  - mem_done clears on the edge after the cycle it was high; the pipeline consumes the result in that cycle (one-cycle pulse).
  - Load data is registered at completion: lane select, then extend per mem_size/mem_signed.
- Best-case latency from the request appearing in IDLE: ext_valid at +1; ready at +2 when ext_ready is already high.
- Store lanes:
  - byte: data[7:0] replicated ×4, strobe = 0001 << addr[1:0].
  - half: data[15:0] ×2, strobe = 0011 << {addr[1],1'b0}; addr[0] ignored.
  - word: strobe = 1111.
- Load lanes: byte from addr[1:0]; half from addr[1] (addr[0] ignored); word unchanged. Alignment checking is the pipeline's responsibility.
- Coherence: a completing store whose word address equals fbuf_addr clears fbuf_valid.
- mem_load and mem_store asserted together are treated as a store.

Decomposition:
- Shared package:
  - size encodings SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2.
  - state enum IDLE/FETCH/MEM.
- Sub-module busio_align (combinational): store replication plus strobe generation, and load extraction plus extension. busio holds the FSM, buffers and arbitration.

Test Plan:
- Fetch 0x100 with ext_ready tied high, ext_read_data = 0x00500093 → ext_valid one cycle at address 0x100; fetch_ready and fetch_data = 0x00500093 two cycles after request; fetch 0x100 held for 5 cycles with no new ext_valid.
- Signed byte load at 0x203, word = 0x80FF7F01 → mem_load_data = 0xFFFFFF80 with mem_ready pulse. Unsigned half at 0x202 → 0x000080FF.
- Store byte 0xAB at 0x301 → ext_write_data = 0xABABABAB, strobe 0010, ext_address 0x300. Store half at 0x302 → strobe 1100.
- Simultaneous fetch miss and load with MEM_FIRST = 1 and ext_ready low for 3 cycles → load issues first with ext_* stable for 3 cycles; fetch issues only after the load completes.
- fetch_address changes 0x100 → 0x400 mid-flight → no fetch_ready for 0x100; a second request to 0x400 follows. A store to 0x400 after it is buffered → fetch_ready drops and 0x400 is refetched.
- reset asserted while ext_valid = 1 → ext_valid = 0 asynchronously and fetch_ready = 0. After release, the pending request reissues from IDLE.
